// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the y86 unified-memory arbiter.
package y86_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_t;

   localparam int FETCH_BYTES = 10;
   localparam int DATA_BYTES  = 8;

endpackage

// File: rtl/y86_mem_bounds.sv
// Combinational range check: flags an access whose last byte would fall past MEM_BYTES-1.
module y86_mem_bounds
   import y86_mem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ACC_BYTES = DATA_BYTES
) (
   input  logic [63:0] addr,
   output logic        err
);

   // Full 64-bit compare so huge addresses never wrap back into range.
   localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - ACC_BYTES);

   assign err = (addr > LAST_OK);

endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbiter sharing one fixed-latency memory between the fetch and data ports.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module y86_mem_arbiter
   import y86_mem_pkg::*;
#(
   parameter int MEM_BYTES  = 1024,
   parameter int LATENCY    = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_ready,
   output logic [79:0] if_rdata,
   output logic        if_err,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [63:0] dm_addr,
   input  logic [63:0] dm_wdata,
   output logic        dm_ready,
   output logic [63:0] dm_rdata,
   output logic        dm_err,
   output logic        mem_en,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [79:0] mem_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [31:0] stat_if_grants,
   output logic [31:0] stat_dm_grants,
   output logic [31:0] stat_stall_cycles
`endif
);

   state_t     state;
   req_id_t    grant_id;
   logic [3:0] lat_cnt;
   logic [7:0] starve_cnt;

   logic        if_oob;
   logic        dm_oob;
   logic        grant;
   logic        pick_if;
   logic        win_err;
   logic [63:0] win_addr;

   y86_mem_bounds #(.MEM_BYTES(MEM_BYTES), .ACC_BYTES(FETCH_BYTES)) u_if_bounds (
      .addr (if_addr),
      .err  (if_oob)
   );

   y86_mem_bounds #(.MEM_BYTES(MEM_BYTES), .ACC_BYTES(DATA_BYTES)) u_dm_bounds (
      .addr (dm_addr),
      .err  (dm_oob)
   );

   // Data normally wins; fetch is forced through once data has starved it STARVE_MAX times.
   always_comb begin
      grant    = (state == IDLE) && (if_req || dm_req);
      pick_if  = if_req && (!dm_req || (starve_cnt == 8'(STARVE_MAX)));
      win_err  = pick_if ? if_oob : dm_oob;
      win_addr = pick_if ? if_addr : dm_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant_id   <= REQ_IF;
         lat_cnt    <= 4'd0;
         starve_cnt <= 8'd0;
         if_ready   <= 1'b0;
         if_rdata   <= 80'd0;
         if_err     <= 1'b0;
         dm_ready   <= 1'b0;
         dm_rdata   <= 64'd0;
         dm_err     <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 64'd0;
         mem_wdata  <= 64'd0;
      end else begin
         case (state)
            IDLE: begin
               if (!if_req) starve_cnt <= 8'd0;
               if (grant) begin
                  if (pick_if) begin
                     grant_id   <= REQ_IF;
                     starve_cnt <= 8'd0;
                  end else begin
                     grant_id <= REQ_DM;
                     if (if_req) starve_cnt <= starve_cnt + 8'd1;
                  end
                  if (win_err) begin
                     state <= RESP;
                     if (pick_if) begin
                        if_ready <= 1'b1;
                        if_err   <= 1'b1;
                        if_rdata <= 80'd0;
                     end else begin
                        dm_ready <= 1'b1;
                        dm_err   <= 1'b1;
                        dm_rdata <= 64'd0;
                     end
                  end else begin
                     state     <= ACCESS;
                     lat_cnt   <= 4'd0;
                     mem_en    <= 1'b1;
                     mem_we    <= !pick_if && dm_we;
                     mem_addr  <= win_addr;
                     mem_wdata <= pick_if ? 64'd0 : dm_wdata;
                  end
               end
            end
            ACCESS: begin
               if (lat_cnt == 4'(LATENCY - 1)) begin
                  state  <= RESP;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  if (grant_id == REQ_IF) begin
                     if_ready <= 1'b1;
                     if_err   <= 1'b0;
                     if_rdata <= mem_rdata;
                  end else begin
                     dm_ready <= 1'b1;
                     dm_err   <= 1'b0;
                     dm_rdata <= mem_we ? 64'd0 : mem_rdata[63:0];
                  end
               end else begin
                  lat_cnt <= lat_cnt + 4'd1;
               end
            end
            RESP: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   // Saturating counters; a stall is any cycle where a requester waits without its ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_if_grants    <= 32'd0;
         stat_dm_grants    <= 32'd0;
         stat_stall_cycles <= 32'd0;
      end else begin
         if (grant && pick_if && (stat_if_grants != 32'hFFFF_FFFF))
            stat_if_grants <= stat_if_grants + 32'd1;
         if (grant && !pick_if && (stat_dm_grants != 32'hFFFF_FFFF))
            stat_dm_grants <= stat_dm_grants + 32'd1;
         if (((if_req && !if_ready) || (dm_req && !dm_ready)) && (stat_stall_cycles != 32'hFFFF_FFFF))
            stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed self-checking bench for y86_mem_arbiter with a byte-array memory model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_y86_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_ready;
   logic [79:0] if_rdata;
   logic        if_err;
   logic        dm_req;
   logic        dm_we;
   logic [63:0] dm_addr;
   logic [63:0] dm_wdata;
   logic        dm_ready;
   logic [63:0] dm_rdata;
   logic        dm_err;
   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [79:0] mem_rdata;
`ifdef ARB_STATS_EN
   logic [31:0] stat_if_grants;
   logic [31:0] stat_dm_grants;
   logic [31:0] stat_stall_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int mem_en_cycles = 0;

   logic [7:0] mem [0:1023];

   y86_mem_arbiter #(.MEM_BYTES(1024), .LATENCY(2), .STARVE_MAX(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ready  (if_ready),
      .if_rdata  (if_rdata),
      .if_err    (if_err),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_ready  (dm_ready),
      .dm_rdata  (dm_rdata),
      .dm_err    (dm_err),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
      ,
      .stat_if_grants    (stat_if_grants),
      .stat_dm_grants    (stat_dm_grants),
      .stat_stall_cycles (stat_stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backing memory: reads are combinational from mem_addr, writes land on the clock edge.
   always @* begin
      logic [63:0] a;
      mem_rdata = 80'd0;
      for (int i = 0; i < 10; i++) begin
         a = mem_addr + 64'(i);
         if (a < 64'd1024) mem_rdata[i*8 +: 8] = mem[a[9:0]];
      end
   end

   always @(posedge clk) begin
      logic [63:0] a;
      if (mem_en) mem_en_cycles <= mem_en_cycles + 1;
      if (mem_en && mem_we) begin
         for (int i = 0; i < 8; i++) begin
            a = mem_addr + 64'(i);
            if (a < 64'd1024) mem[a[9:0]] <= mem_wdata[i*8 +: 8];
         end
      end
   end

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a * 7 + 3);
   endfunction

   function automatic logic [79:0] init_bytes(input int a, input int n);
      logic [79:0] v;
      v = 80'd0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = init_byte(a + i);
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input bit want_if, output int n, output bit ok);
      ok = 1'b0;
      n  = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         n++;
         if (want_if ? if_ready : dm_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({if_ready, if_err, dm_ready, dm_err, mem_en, mem_we} !== 6'd0 ||
          if_rdata !== 80'd0 || dm_rdata !== 64'd0 || mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: if_ready=%b dm_ready=%b mem_en=%b mem_addr=%h required all zero",
                  if_ready, dm_ready, mem_en, mem_addr);
      end
`ifdef ARB_STATS_EN
      checks++;
      if (stat_if_grants !== 32'd0 || stat_dm_grants !== 32'd0 || stat_stall_cycles !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_stats: got %0d/%0d/%0d required 0/0/0",
                  stat_if_grants, stat_dm_grants, stat_stall_cycles);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_fetch_only;
      logic [79:0] exp;
      exp     = init_bytes(16, 10);
      if_addr = 64'h10;
      if_req  = 1'b1;
      tick();
      checks++;
      if (mem_en !== 1'b1 || if_ready !== 1'b0 || mem_addr !== 64'h10 || mem_we !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_cycle1: mem_en=%b if_ready=%b mem_addr=%h required 1/0/10", mem_en, if_ready, mem_addr);
      end
      tick();
      checks++;
      if (mem_en !== 1'b1 || if_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_cycle2: mem_en=%b if_ready=%b required 1/0", mem_en, if_ready);
      end
      tick();
      checks++;
      if (mem_en !== 1'b0 || if_ready !== 1'b1 || if_err !== 1'b0 || dm_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_ready: mem_en=%b if_ready=%b if_err=%b dm_ready=%b required 0/1/0/0",
                  mem_en, if_ready, if_err, dm_ready);
      end
      checks++;
      if (if_rdata !== exp) begin
         errors++;
         $display("[TB] FAIL fetch_rdata: got %h required %h", if_rdata, exp);
      end
      if_req = 1'b0;
      tick();
      checks++;
      if (if_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fetch_pulse_width: if_ready=%b required 0", if_ready);
      end
   endtask

   task automatic test_data_write_read;
      int n;
      bit ok;
      dm_addr  = 64'h200;
      dm_wdata = 64'h1122334455667788;
      dm_we    = 1'b1;
      dm_req   = 1'b1;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 3 || dm_err !== 1'b0 || dm_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL write_resp: ok=%0d cycles=%0d err=%b rdata=%h required 1/3/0/0", ok, n, dm_err, dm_rdata);
      end
      dm_we = 1'b0;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 4) begin
         errors++;
         $display("[TB] FAIL write_read_spacing: ok=%0d cycles=%0d required 1/4", ok, n);
      end
      checks++;
      if (dm_rdata !== 64'h1122334455667788 || dm_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_back: got %h err=%b required 1122334455667788 err=0", dm_rdata, dm_err);
      end
      dm_req = 1'b0;
      tick();
   endtask

   task automatic test_bounds;
      int n;
      bit ok;
      int base;
      logic [63:0] exp;
      base    = mem_en_cycles;
      if_addr = 64'd1015;
      if_req  = 1'b1;
      wait_ready(1'b1, n, ok);
      checks++;
      if (!ok || n != 1 || if_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL if_oob_1015: ok=%0d cycles=%0d err=%b required 1/1/1", ok, n, if_err);
      end
      if_req = 1'b0;
      tick();
      checks++;
      if (mem_en_cycles != base || if_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL if_oob_no_mem: mem_en cycles=%0d if_ready=%b required 0/0", mem_en_cycles - base, if_ready);
      end

      if_addr = 64'd1014;
      if_req  = 1'b1;
      wait_ready(1'b1, n, ok);
      checks++;
      if (!ok || n != 3 || if_err !== 1'b0 || if_rdata !== init_bytes(1014, 10)) begin
         errors++;
         $display("[TB] FAIL if_edge_1014: ok=%0d cycles=%0d err=%b rdata=%h required 1/3/0/%h",
                  ok, n, if_err, if_rdata, init_bytes(1014, 10));
      end
      if_req = 1'b0;
      tick();

      exp     = 64'(init_bytes(1016, 8));
      dm_addr = 64'd1016;
      dm_we   = 1'b0;
      dm_req  = 1'b1;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 3 || dm_err !== 1'b0 || dm_rdata !== exp) begin
         errors++;
         $display("[TB] FAIL dm_edge_1016: ok=%0d cycles=%0d err=%b rdata=%h required 1/3/0/%h", ok, n, dm_err, dm_rdata, exp);
      end
      dm_req = 1'b0;
      tick();

      dm_addr = 64'd1017;
      dm_req  = 1'b1;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 1 || dm_err !== 1'b1 || dm_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL dm_oob_1017: ok=%0d cycles=%0d err=%b rdata=%h required 1/1/1/0", ok, n, dm_err, dm_rdata);
      end
      dm_req = 1'b0;
      tick();

      dm_addr = 64'hFFFF_FFFF_FFFF_FFF8;
      dm_req  = 1'b1;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 1 || dm_err !== 1'b1) begin
         errors++;
         $display("[TB] FAIL dm_oob_wrap: ok=%0d cycles=%0d err=%b required 1/1/1", ok, n, dm_err);
      end
      dm_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_access;
      int n;
      bit ok;
      int stray;
      dm_addr = 64'h40;
      dm_we   = 1'b0;
      dm_req  = 1'b1;
      tick();
      checks++;
      if (mem_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_mid_started: mem_en=%b required 1", mem_en);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (mem_en !== 1'b0 || mem_we !== 1'b0 || dm_ready !== 1'b0 || if_ready !== 1'b0 ||
          mem_addr !== 64'd0 || dm_rdata !== 64'd0) begin
         errors++;
         $display("[TB] FAIL rst_mid_outputs: mem_en=%b dm_ready=%b mem_addr=%h required 0/0/0", mem_en, dm_ready, mem_addr);
      end
      rst    = 1'b0;
      dm_req = 1'b0;
      stray  = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (dm_ready || mem_en) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("[TB] FAIL rst_mid_quiet: activity cycles=%0d required 0", stray);
      end
      dm_req = 1'b1;
      wait_ready(1'b0, n, ok);
      checks++;
      if (!ok || n != 3 || dm_rdata !== 64'(init_bytes(64, 8))) begin
         errors++;
         $display("[TB] FAIL rst_mid_recover: ok=%0d cycles=%0d rdata=%h required 1/3/%h",
                  ok, n, dm_rdata, 64'(init_bytes(64, 8)));
      end
      dm_req = 1'b0;
      tick();
   endtask

   task automatic test_starvation;
      bit ok;
      bit got_if;
      bit exp_if;
`ifdef ARB_STATS_EN
      logic [31:0] if0;
      logic [31:0] dm0;
      if0 = stat_if_grants;
      dm0 = stat_dm_grants;
`endif
      if_addr = 64'h20;
      dm_addr = 64'h100;
      dm_we   = 1'b0;
      if_req  = 1'b1;
      dm_req  = 1'b1;
      for (int k = 0; k < 20; k++) begin
         ok = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (if_ready || dm_ready) begin
               ok = 1'b1;
               break;
            end
         end
         got_if = if_ready;
         exp_if = ((k % 4) == 3);
         checks++;
         if (!ok || (if_ready && dm_ready) || got_if != exp_if) begin
            errors++;
            $display("[TB] FAIL starve_grant_%0d: ok=%0d if_ready=%b dm_ready=%b required fetch=%0d",
                     k, ok, if_ready, dm_ready, exp_if);
         end
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      tick();
      tick();
`ifdef ARB_STATS_EN
      checks++;
      if (stat_if_grants - if0 !== 32'd5 || stat_dm_grants - dm0 !== 32'd15) begin
         errors++;
         $display("[TB] FAIL stats_grants: if=%0d dm=%0d required 5/15", stat_if_grants - if0, stat_dm_grants - dm0);
      end
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
      rst      = 1'b1;
      if_req   = 1'b0;
      if_addr  = 64'd0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_addr  = 64'd0;
      dm_wdata = 64'd0;
      test_reset();
      test_fetch_only();
      test_data_write_read();
      test_bounds();
      test_reset_mid_access();
      test_starvation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
Shares one single-port, byte-addressed unified memory between two requesters in the y86 pipeline: the fetch-stage instruction port (10-byte reads) and the memory-stage data port (8-byte reads/writes).
- Sequences each access over a fixed-latency memory.
- Decides priority, with a starvation guard for fetch.
- Flags out-of-range addresses as imem/dmem errors.
- Sits between fetch/memory stages and the backing memory array; the hazard controller treats `if_ready`/`dm_ready` low as stall sources.

Parameters:
- MEM_BYTES, 1024: size of backing memory in bytes; valid addresses 0..MEM_BYTES-1.
- LATENCY, 2: memory access cycles per granted access; legal range 1..15.
- STARVE_MAX, 3: consecutive data grants allowed while `if_req` is pending before fetch is forced to win.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held until `if_ready`
- if_addr  in  64  fetch byte address
- if_ready  out  1  one-cycle pulse: `if_rdata`/`if_err` valid
- if_rdata  out  80  bytes addr..addr+9; byte at addr in bits [7:0]
- if_err  out  1  fetch address out of range
- dm_req  in  1  data request; held until `dm_ready`
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  64  data byte address
- dm_wdata  in  64  write data, little-endian
- dm_ready  out  1  one-cycle pulse: `dm_rdata`/`dm_err` valid
- dm_rdata  out  64  read data (0 on write or error)
- dm_err  out  1  data address out of range
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  64  memory byte address
- mem_wdata  out  64  memory write data
- mem_rdata  in  80  10 bytes from `mem_addr`, valid on the last `mem_en` cycle

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; latency counter 0; starve counter 0. `rst` mid-access aborts the access: no ready pulse, `mem_en`/`mem_we` low next cycle, memory content undefined only for an aborted write.
- States: IDLE, ACCESS, RESP.
  - IDLE: requests are sampled at each edge.
  - If the winner's address range fails the bounds check, go to RESP with err=1; no `mem_en`. Error response arrives 1 cycle after the grant edge.
  - Otherwise go to ACCESS.
- Bounds check: fetch fails if `addr > MEM_BYTES-10`; data fails if `addr > MEM_BYTES-8`. Computed on full 64 bits; no wrap-around.
- ACCESS:
  - `mem_en`=1 and `mem_addr`/`mem_we`/`mem_wdata` are stable for exactly LATENCY cycles.
  - At the edge ending the last cycle, capture `mem_rdata`, then go to RESP.
- RESP:
  - Exactly one of `if_ready`/`dm_ready` is high for one cycle, with registered data/err.
  - Always returns to IDLE.
- Latency: grant edge k → ready high in the cycle after edge k+LATENCY. Back-to-back accesses are LATENCY+2 cycles apart.
- Requesters deassert req in their ready cycle. Req must be held from assertion until ready.
- Req dropped mid-ACCESS: the access completes, a write still commits, and the ready pulse is still issued.
- Priority when both requesters are pending in IDLE:
  - Data wins unless starve counter == STARVE_MAX, in which case fetch wins.
  - The starve counter increments on each data grant while `if_req`=1; it clears on any fetch grant or when `if_req`=0 in IDLE.
- Data writes update 8 bytes. Data reads return `mem_rdata[63:0]`. Fetch returns all 80 bits.

Optional Feature:
ARB_STATS_EN
- Defined: adds output ports `stat_if_grants`, `stat_dm_grants` and `stat_stall_cycles` (32-bit each).
  - The grant counters count grants.
  - `stat_stall_cycles` counts cycles where any req=1 and its ready=0.
  - All counters saturate at 2^32-1 and reset to 0.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package y86_mem_pkg:
  - state enum (IDLE/ACCESS/RESP)
  - constants FETCH_BYTES=10, DATA_BYTES=8
  - requester-id encoding
- One sub-module, y86_mem_bounds: combinational range check, instantiated once per port.

Test Plan:
- Fetch-only: `if_req`=1, `if_addr`=0x10, LATENCY=2 → `mem_en` high 2 cycles; `if_ready` pulse at edge+3; `if_rdata` = mem bytes 0x10..0x19; `if_err`=0.
- Data write then read: write 0x1122334455667788 to 0x200, then read 0x200 → `dm_rdata`=0x1122334455667788; accesses spaced 4 cycles apart.
- Starvation: `if_req` and `dm_req` held continuously, STARVE_MAX=3 → grant sequence DM, DM, DM, IF, DM…
- Bounds: `if_addr`=1015 with MEM_BYTES=1024 → `if_err`=1, `if_ready` at edge+1, `mem_en` never high. `dm_addr`=1016 → ok; `dm_addr`=1017 → err.
- Reset mid-access: `rst` during ACCESS of a data read → no `dm_ready`, all outputs 0 next cycle; a new request is granted normally after `rst` drops.
- Stats (ARB_STATS_EN): run the starvation scenario for 20 accesses → `stat_if_grants`=5, `stat_dm_grants`=15.
